// File: rtl/cpu_sequencer_pkg.sv
// Shared types and constants for the multicycle CPU sequencer.
//   state_t   - sequencer FSM state encoding
//   ctrl_t    - bundle of every control strobe the sequencer drives
//   OP_*      - instruction opcode field values (instr[15:13])
//   REG_SEL_* - register-field select encodings
//   WB_SEL_*  - writeback source encodings
package cpu_pkg;

  typedef enum logic [4:0] {
    StWait, StIf1, StIf2, StUpc, StDec, StWimm, StGeta, StGetb, StExec,
    StWb, StAddr, StLda, StMrd, StMwb, StGetd, StPass, StStw, StHalt
  } state_t;

  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;
  localparam logic [2:0] OP_LDR = 3'b011;
  localparam logic [2:0] OP_STR = 3'b100;
  localparam logic [2:0] OP_HLT = 3'b111;

  localparam logic [1:0] REG_SEL_RM = 2'b00;
  localparam logic [1:0] REG_SEL_RD = 2'b01;
  localparam logic [1:0] REG_SEL_RN = 2'b10;

  localparam logic [1:0] WB_SEL_C   = 2'b00;
  localparam logic [1:0] WB_SEL_PC  = 2'b01;
  localparam logic [1:0] WB_SEL_IMM = 2'b10;
  localparam logic [1:0] WB_SEL_RAM = 2'b11;

  typedef struct packed {
    logic       waiting;
    logic [1:0] reg_sel;
    logic [1:0] wb_sel;
    logic       w_en;
    logic       en_a;
    logic       en_b;
    logic       en_c;
    logic       en_status;
    logic       sel_a;
    logic       sel_b;
    logic       clear_pc;
    logic       load_pc;
    logic       load_ir;
    logic       load_addr;
    logic       sel_addr;
    logic       ram_w_en;
  } ctrl_t;

  // Strobes presented while idling in WAIT (and therefore during reset).
  localparam ctrl_t CTRL_WAIT = '{waiting: 1'b1, clear_pc: 1'b1, load_pc: 1'b1, default: '0};

  // CMP only updates status; it never produces a result in C.
  function automatic logic is_cmp(logic [2:0] opcode, logic [1:0] op);
    return (opcode == OP_ALU) && (op == 2'b01);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control bundle between the sequencer and the decoder/datapath/RAM.
//   master - sequencer side: takes start/opcode/op, drives every strobe
//   slave  - datapath side: the mirror image
interface cpu_sequencer_if;
  logic       start;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       waiting;
  logic [1:0] reg_sel;
  logic [1:0] wb_sel;
  logic       w_en;
  logic       en_A;
  logic       en_B;
  logic       en_C;
  logic       en_status;
  logic       sel_A;
  logic       sel_B;
  logic       clear_pc;
  logic       load_pc;
  logic       load_ir;
  logic       load_addr;
  logic       sel_addr;
  logic       ram_w_en;
  logic       illegal;

  modport master (
    input  start, opcode, op,
    output waiting, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B,
           clear_pc, load_pc, load_ir, load_addr, sel_addr, ram_w_en, illegal
  );

  modport slave (
    output start, opcode, op,
    input  waiting, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B,
           clear_pc, load_pc, load_ir, load_addr, sel_addr, ram_w_en, illegal
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multicycle control FSM for the simple RISC machine: fetch, PC update,
// register read, execute, writeback and RAM load/store. Holds no data.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous reset, ACTIVE-HIGH despite the name
//   bus   - cpu_sequencer_if.master (start/opcode/op in, strobes out)
// Parameter RAM_RD_LAT must be 1.
// Macro ILLEGAL_HALT_EN: an unlisted opcode/op halts and sets a sticky
// illegal flag; when undefined it is a NOP and illegal is tied low.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned RAM_RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  cpu_sequencer_if.master    bus
);

  if (RAM_RD_LAT != 1) begin : g_bad_lat
    $fatal(1, "cpu_sequencer: only RAM_RD_LAT == 1 is supported");
  end

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

`ifdef ILLEGAL_HALT_EN
  logic illegal_q, illegal_d;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
`ifdef ILLEGAL_HALT_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      StWait: if (bus.start) state_d = StIf1;
      StIf1:  state_d = StIf2;
      StIf2:  state_d = StUpc;
      StUpc:  state_d = StDec;
      StDec: begin
        if (bus.opcode == OP_MOV && bus.op == 2'b10)      state_d = StWimm;
        else if (bus.opcode == OP_MOV && bus.op == 2'b00) state_d = StGetb;
        else if (bus.opcode == OP_ALU)                    state_d = (bus.op == 2'b11) ? StGetb
                                                                                      : StGeta;
        else if (bus.opcode == OP_LDR || bus.opcode == OP_STR) state_d = StGeta;
        else if (bus.opcode == OP_HLT)                    state_d = StHalt;
        else begin
`ifdef ILLEGAL_HALT_EN
          state_d   = StHalt;
          illegal_d = 1'b1;
`else
          state_d = StIf1;
`endif
        end
      end
      StWimm: state_d = StIf1;
      StGeta: state_d = (bus.opcode == OP_ALU) ? StGetb : StAddr;
      StGetb: state_d = StExec;
      StExec: state_d = is_cmp(bus.opcode, bus.op) ? StIf1 : StWb;
      StWb:   state_d = StIf1;
      StAddr: state_d = StLda;
      StLda:  state_d = (bus.opcode == OP_LDR) ? StMrd : StGetd;
      StMrd:  state_d = StMwb;
      StMwb:  state_d = StIf1;
      StGetd: state_d = StPass;
      StPass: state_d = StStw;
      StStw:  state_d = StIf1;
      StHalt: state_d = StHalt;
      default: state_d = StWait;
    endcase
  end

  // Output decode of the next state, so the registered strobes line up
  // exactly with state_q and come straight from flops.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      StWait: ctrl_d = CTRL_WAIT;
      StIf1:  ctrl_d.sel_addr = 1'b1;
      StIf2: begin
        ctrl_d.sel_addr = 1'b1;
        ctrl_d.load_ir  = 1'b1;
      end
      StUpc:  ctrl_d.load_pc = 1'b1;
      StWimm: begin
        ctrl_d.reg_sel = REG_SEL_RN;
        ctrl_d.wb_sel  = WB_SEL_IMM;
        ctrl_d.w_en    = 1'b1;
      end
      StGeta: begin
        ctrl_d.reg_sel = REG_SEL_RN;
        ctrl_d.en_a    = 1'b1;
      end
      StGetb: begin
        ctrl_d.reg_sel = REG_SEL_RM;
        ctrl_d.en_b    = 1'b1;
      end
      StExec: begin
        ctrl_d.en_status = is_cmp(bus.opcode, bus.op);
        ctrl_d.en_c      = !is_cmp(bus.opcode, bus.op);
        // MOV-reg and MVN pass B through with a zero A operand.
        ctrl_d.sel_a     = (bus.opcode == OP_MOV) || (bus.opcode == OP_ALU && bus.op == 2'b11);
      end
      StWb: begin
        ctrl_d.reg_sel = REG_SEL_RD;
        ctrl_d.wb_sel  = WB_SEL_C;
        ctrl_d.w_en    = 1'b1;
      end
      StAddr: begin
        ctrl_d.sel_b = 1'b1;
        ctrl_d.en_c  = 1'b1;
      end
      StLda:  ctrl_d.load_addr = 1'b1;
      StMwb: begin
        ctrl_d.reg_sel = REG_SEL_RD;
        ctrl_d.wb_sel  = WB_SEL_RAM;
        ctrl_d.w_en    = 1'b1;
      end
      StGetd: begin
        ctrl_d.reg_sel = REG_SEL_RD;
        ctrl_d.en_b    = 1'b1;
      end
      StPass: begin
        ctrl_d.sel_a = 1'b1;
        ctrl_d.en_c  = 1'b1;
      end
      StStw:  ctrl_d.ram_w_en = 1'b1;
      StHalt: ctrl_d.waiting  = 1'b1;
      default: ctrl_d = '0;  // DEC and MRD drive nothing
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= StWait;
      ctrl_q    <= CTRL_WAIT;
`ifdef ILLEGAL_HALT_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
`ifdef ILLEGAL_HALT_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign bus.waiting   = ctrl_q.waiting;
  assign bus.reg_sel   = ctrl_q.reg_sel;
  assign bus.wb_sel    = ctrl_q.wb_sel;
  assign bus.w_en      = ctrl_q.w_en;
  assign bus.en_A      = ctrl_q.en_a;
  assign bus.en_B      = ctrl_q.en_b;
  assign bus.en_C      = ctrl_q.en_c;
  assign bus.en_status = ctrl_q.en_status;
  assign bus.sel_A     = ctrl_q.sel_a;
  assign bus.sel_B     = ctrl_q.sel_b;
  assign bus.clear_pc  = ctrl_q.clear_pc;
  assign bus.load_pc   = ctrl_q.load_pc;
  assign bus.load_ir   = ctrl_q.load_ir;
  assign bus.load_addr = ctrl_q.load_addr;
  assign bus.sel_addr  = ctrl_q.sel_addr;
  assign bus.ram_w_en  = ctrl_q.ram_w_en;
`ifdef ILLEGAL_HALT_EN
  assign bus.illegal   = illegal_q;
`else
  assign bus.illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus pushes the expected strobe
// vector for each upcoming cycle, a negedge monitor pops and compares.
module tb_cpu_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cpu_sequencer_if bus ();

  cpu_sequencer #(.RAM_RD_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef enum int {
    PW, PI1, PI2, PUPC, PDEC, PWIMM, PGETA, PGETB, PEXEC, PWB, PADDR, PLDA, PMRD, PMWB,
    PGETD, PPASS, PSTW, PHALT
  } ph_e;

  typedef struct packed {
    logic       waiting;
    logic [1:0] reg_sel;
    logic [1:0] wb_sel;
    logic       w_en, en_a, en_b, en_c, en_status, sel_a, sel_b;
    logic       clear_pc, load_pc, load_ir, load_addr, sel_addr, ram_w_en, illegal;
  } vec_t;

  typedef struct {
    vec_t  v;
    string tag;
  } item_t;

  item_t      q[$];
  int         errors = 0;
  int         checks = 0;
  logic [2:0] cur_opc = '0;
  logic [1:0] cur_op  = '0;
  logic       exp_ill = 1'b0;

  // Hand-written strobe table per phase.
  function automatic vec_t exp_vec(ph_e ph, logic [2:0] opc, logic [1:0] o, logic ill);
    vec_t c;
    c = '0;
    case (ph)
      PW:    begin c.waiting = 1; c.clear_pc = 1; c.load_pc = 1; end
      PI1:   c.sel_addr = 1;
      PI2:   begin c.sel_addr = 1; c.load_ir = 1; end
      PUPC:  c.load_pc = 1;
      PWIMM: begin c.reg_sel = 2'b10; c.wb_sel = 2'b10; c.w_en = 1; end
      PGETA: begin c.reg_sel = 2'b10; c.en_a = 1; end
      PGETB: begin c.reg_sel = 2'b00; c.en_b = 1; end
      PEXEC: begin
        if (opc == 3'b101 && o == 2'b01) c.en_status = 1;
        else c.en_c = 1;
        if (opc == 3'b110 || (opc == 3'b101 && o == 2'b11)) c.sel_a = 1;
      end
      PWB:   begin c.reg_sel = 2'b01; c.wb_sel = 2'b00; c.w_en = 1; end
      PADDR: begin c.sel_b = 1; c.en_c = 1; end
      PLDA:  c.load_addr = 1;
      PMWB:  begin c.reg_sel = 2'b01; c.wb_sel = 2'b11; c.w_en = 1; end
      PGETD: begin c.reg_sel = 2'b01; c.en_b = 1; end
      PPASS: begin c.sel_a = 1; c.en_c = 1; end
      PSTW:  c.ram_w_en = 1;
      PHALT: c.waiting = 1;
      default: ;
    endcase
    c.illegal = ill;
    return c;
  endfunction

  task automatic push(ph_e ph);
    item_t it;
    it.v   = exp_vec(ph, cur_opc, cur_op, exp_ill);
    it.tag = $sformatf("%s_op%b_%b", ph.name(), cur_opc, cur_op);
    q.push_back(it);
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Call while in WAIT: one WAIT cycle with start high, leaves FSM entering IF1.
  task automatic kick();
    bus.start = 1'b1;
    push(PW);
    step(1);
    bus.start = 1'b0;
  endtask

  // Call as the FSM enters IF1.
  task automatic fetch(logic [2:0] opc, logic [1:0] o);
    cur_opc    = opc;
    cur_op     = o;
    bus.opcode = opc;
    bus.op     = o;
    push(PI1);
    push(PI2);
    push(PUPC);
    push(PDEC);
  endtask

  // Monitor: outputs are valid every cycle, compare on the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      vec_t  act;
      it  = q.pop_front();
      act = '{bus.waiting, bus.reg_sel, bus.wb_sel, bus.w_en, bus.en_A, bus.en_B, bus.en_C,
              bus.en_status, bus.sel_A, bus.sel_B, bus.clear_pc, bus.load_pc, bus.load_ir,
              bus.load_addr, bus.sel_addr, bus.ram_w_en, bus.illegal};
      checks++;
      if (act !== it.v) begin
        errors++;
        $display("FAIL %s: got %b want %b", it.tag, act, it.v);
      end
    end
  end

  initial begin
    int waited;
    bus.start  = 1'b0;
    bus.opcode = '0;
    bus.op     = '0;

    // Reset held three cycles, then idle with start low.
    step(1);
    repeat (3) push(PW);
    step(3);
    rst_n = 1'b0;
    repeat (5) push(PW);
    step(5);

    // MOV R0,#7
    kick();
    fetch(3'b110, 2'b10); push(PWIMM); step(5);
    // ADD R2,R0,R1
    fetch(3'b101, 2'b00); push(PGETA); push(PGETB); push(PEXEC); push(PWB); step(8);
    // CMP
    fetch(3'b101, 2'b01); push(PGETA); push(PGETB); push(PEXEC); step(7);
    // MOV reg
    fetch(3'b110, 2'b00); push(PGETB); push(PEXEC); push(PWB); step(7);
    // MVN
    fetch(3'b101, 2'b11); push(PGETB); push(PEXEC); push(PWB); step(7);
    // LDR R1,[R0,#3]
    fetch(3'b011, 2'b00); push(PGETA); push(PADDR); push(PLDA); push(PMRD); push(PMWB);
    step(9);
    // STR
    fetch(3'b100, 2'b00); push(PGETA); push(PADDR); push(PLDA); push(PGETD); push(PPASS);
    push(PSTW); step(10);
    // Unlisted opcode 000
    fetch(3'b000, 2'b00);
`ifdef ILLEGAL_HALT_EN
    exp_ill = 1'b1;
    push(PHALT); push(PHALT); step(6);
    rst_n   = 1'b1;
    exp_ill = 1'b0;
    push(PW); step(1);
    rst_n = 1'b0;
    push(PW); step(1);
    kick();
`else
    step(4);
`endif
    // ADD aborted by reset just after entering EXEC.
    fetch(3'b101, 2'b00); push(PGETA); push(PGETB); step(6);
    rst_n = 1'b1;
    push(PW); push(PW); step(2);
    rst_n = 1'b0;
    push(PW); step(1);

    // HALT, then start toggling is ignored.
    kick();
    fetch(3'b111, 2'b00); push(PHALT); step(5);
    for (int i = 0; i < 4; i++) begin
      bus.start = (i % 2 == 0);
      push(PHALT);
      step(1);
    end
    bus.start = 1'b0;

    waited = 0;
    while (q.size() > 0 && waited < 50) begin
      step(1);
      waited++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
